vga_timing_generation: RTL and testbench



---
 rtl/vga_timing_generation.sv | 87 ++++++++
 tb/tb_vga_timing_generation.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_generation.sv
// 640x480@60Hz VGA sync generator: clk is divided down to a pixel tick that
// advances horizontal/vertical counters; syncs and pixel coordinates decode them.
module vga_timing_generation #(
    parameter int clk_freq   = 50000000,
    parameter int pixel_freq = 25000000,
    parameter int h_visible  = 640,
    parameter int h_front    = 16,
    parameter int h_sync_len = 96,
    parameter int h_back     = 48,
    parameter int v_visible  = 480,
    parameter int v_front    = 10,
    parameter int v_sync_len = 2,
    parameter int v_back     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       h_sync,
    output logic       v_sync,
    output logic [9:0] h_pixel,
    output logic [8:0] v_pixel
);

    localparam int DIV     = (pixel_freq > 0) ? clk_freq / pixel_freq : 1;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int H_TOTAL = h_visible + h_front + h_sync_len + h_back;
    localparam int V_TOTAL = v_visible + v_front + v_sync_len + v_back;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(h_visible);
    localparam logic [9:0] H_PIX_MAX    = 10'(h_visible - 1);
    localparam logic [9:0] H_SYNC_START = 10'(h_visible + h_front);
    localparam logic [9:0] H_SYNC_END   = 10'(h_visible + h_front + h_sync_len);

    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS        = 10'(v_visible);
    localparam logic [8:0] V_PIX_MAX    = 9'(v_visible - 1);
    localparam logic [9:0] V_SYNC_START = 10'(v_visible + v_front);
    localparam logic [9:0] V_SYNC_END   = 10'(v_visible + v_front + v_sync_len);

    // A non-integer divide ratio or oversized geometry cannot be built correctly.
    generate
        if ((pixel_freq <= 0) || (clk_freq < pixel_freq) ||
            ((clk_freq % ((pixel_freq > 0) ? pixel_freq : 1)) != 0)) begin : g_bad_div
            $error("vga_timing_generation: clk_freq must be an integer multiple of pixel_freq");
        end
        if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (h_visible < 1) || (v_visible < 1) ||
            (v_visible > 512)) begin : g_bad_geom
            $error("vga_timing_generation: timing geometry does not fit counter widths");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // Coordinates clamp to the last visible pixel/line during blanking.
    always_comb begin
        h_sync  = ~((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
        v_sync  = ~((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
        h_pixel = (h_cnt < H_VIS) ? h_cnt : H_PIX_MAX;
        v_pixel = (v_cnt < V_VIS) ? v_cnt[8:0] : V_PIX_MAX;
    end

endmodule

// File: tb/tb_vga_timing_generation.sv
// Scoreboard bench: a default 640x480 instance for line timing and a shrunken
// instance (DIV=3, 15x8 totals) for frame wrap, sync and mid-frame reset.
module tb_vga_timing_generation;

    typedef struct {
        int    t;
        bit    hs;
        bit    vs;
        int    hp;
        int    vp;
        string name;
    } exp_t;

    logic       clk;
    logic       rst_a, rst_b;
    logic       hs_a, vs_a, hs_b, vs_b;
    logic [9:0] hp_a, hp_b;
    logic [8:0] vp_a, vp_b;

    int   t_a = -1;
    int   t_b = -1;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];

    vga_timing_generation u_dut (
        .clk(clk), .reset(rst_a), .h_sync(hs_a), .v_sync(vs_a),
        .h_pixel(hp_a), .v_pixel(vp_a)
    );

    vga_timing_generation #(
        .clk_freq(3), .pixel_freq(1),
        .h_visible(8), .h_front(2), .h_sync_len(3), .h_back(2),
        .v_visible(4), .v_front(1), .v_sync_len(2), .v_back(1)
    ) u_small (
        .clk(clk), .reset(rst_b), .h_sync(hs_b), .v_sync(vs_b),
        .h_pixel(hp_b), .v_pixel(vp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since the last reset edge; counters are all-zero at t=0.
    always @(posedge clk) t_a <= rst_a ? 0 : t_a + 1;
    always @(posedge clk) t_b <= rst_b ? 0 : t_b + 1;

    task automatic push_a(input int t, input bit hs, input bit vs, input int hp, input int vp,
                          input string nm);
        exp_t e;
        e.t = t; e.hs = hs; e.vs = vs; e.hp = hp; e.vp = vp; e.name = nm;
        qa.push_back(e);
    endtask

    task automatic push_b(input int t, input bit hs, input bit vs, input int hp, input int vp,
                          input string nm);
        exp_t e;
        e.t = t; e.hs = hs; e.vs = vs; e.hp = hp; e.vp = vp; e.name = nm;
        qb.push_back(e);
    endtask

    task automatic check(input exp_t e, input int t, input logic hs, input logic vs,
                         input logic [9:0] hp, input logic [8:0] vp);
        n_tests++;
        if (hs !== e.hs || vs !== e.vs || int'(hp) != e.hp || int'(vp) != e.vp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got hs=%0b vs=%0b hp=%0d vp=%0d, expected hs=%0b vs=%0b hp=%0d vp=%0d",
                     e.name, t, hs, vs, hp, vp, e.hs, e.vs, e.hp, e.vp);
        end
    endtask

    task automatic missed(input exp_t e, input int t);
        n_tests++;
        n_fail++;
        $display("FAIL %s: expected at t=%0d, not observed (now t=%0d)", e.name, e.t, t);
    endtask

    always @(negedge clk) begin
        if (qa.size() > 0 && qa[0].t < t_a) begin
            missed(qa[0], t_a);
            void'(qa.pop_front());
        end else if (qa.size() > 0 && qa[0].t == t_a) begin
            check(qa[0], t_a, hs_a, vs_a, hp_a, vp_a);
            void'(qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (qb.size() > 0 && qb[0].t < t_b) begin
            missed(qb[0], t_b);
            void'(qb.pop_front());
        end else if (qb.size() > 0 && qb[0].t == t_b) begin
            check(qb[0], t_b, hs_b, vs_b, hp_b, vp_b);
            void'(qb.pop_front());
        end
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_a(0, 1, 1, 0, 0, "A reset held");
            push_b(0, 1, 1, 0, 0, "B reset held");
        end

        // Default geometry, DIV=2: h_cnt = t/2, line = 1600 clks.
        push_a(1,    1, 1, 0,   0, "A div first pixel");
        push_a(2,    1, 1, 1,   0, "A div step 1");
        push_a(3,    1, 1, 1,   0, "A div hold 1");
        push_a(4,    1, 1, 2,   0, "A div step 2");
        push_a(1279, 1, 1, 639, 0, "A last visible");
        push_a(1280, 1, 1, 639, 0, "A clamp h640");
        push_a(1311, 1, 1, 639, 0, "A before hsync");
        push_a(1312, 0, 1, 639, 0, "A hsync fall h656");
        push_a(1503, 0, 1, 639, 0, "A hsync last h751");
        push_a(1504, 1, 1, 639, 0, "A hsync rise h752");
        push_a(1599, 1, 1, 639, 0, "A line end h799");
        push_a(1600, 1, 1, 0,   1, "A line 1 start");
        push_a(1602, 1, 1, 1,   1, "A line 1 px1");
        push_a(3200, 1, 1, 0,   2, "A line 2 start");

        // Small geometry, DIV=3: h = (t/3)%15, v = (t/45)%8, frame = 360 clks.
        push_b(2,   1, 1, 0, 0, "B div hold 0");
        push_b(3,   1, 1, 1, 0, "B div step 1");
        push_b(23,  1, 1, 7, 0, "B last visible");
        push_b(24,  1, 1, 7, 0, "B clamp h8");
        push_b(29,  1, 1, 7, 0, "B before hsync");
        push_b(30,  0, 1, 7, 0, "B hsync fall");
        push_b(38,  0, 1, 7, 0, "B hsync last");
        push_b(39,  1, 1, 7, 0, "B hsync rise");
        push_b(44,  1, 1, 7, 0, "B line end");
        push_b(45,  1, 1, 0, 1, "B line 1 start");
        push_b(180, 1, 1, 0, 3, "B line 4 clamp v");
        push_b(224, 1, 1, 7, 3, "B before vsync");
        push_b(225, 1, 0, 0, 3, "B vsync fall");
        push_b(314, 1, 0, 7, 3, "B vsync last");
        push_b(315, 1, 1, 0, 3, "B vsync rise");
        push_b(359, 1, 1, 7, 3, "B frame end");
        push_b(360, 1, 1, 0, 0, "B frame wrap");
        push_b(361, 1, 1, 0, 0, "B wrap hold");
        push_b(363, 1, 1, 1, 0, "B wrap step");
        push_b(460, 1, 1, 3, 2, "B mid-frame state");

        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        for (int i = 0; i < 2000 && t_b != 460; i++) @(negedge clk);
        if (t_b != 460) begin
            n_tests++;
            n_fail++;
            $display("FAIL B reach mid-frame: t=%0d, expected 460", t_b);
        end
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        push_b(0, 1, 1, 0, 0, "B mid-frame reset");
        @(negedge clk);
        rst_b = 1'b0;
        push_b(2,  1, 1, 0, 0, "B restart hold 0");
        push_b(3,  1, 1, 1, 0, "B restart step 1");
        push_b(30, 0, 1, 7, 0, "B restart hsync");
        push_b(45, 1, 1, 0, 1, "B restart line 1");

        for (int i = 0; i < 6000 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
        foreach (qa[i]) missed(qa[i], t_a);
        foreach (qb[i]) missed(qb[i], t_b);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
